operand_issue_fifo: RTL

Upstream feeder for the N-bit operand stage that consumes a/b and produces c. It accepts operand pairs from a producer over a valid/ready handshake and buffers them in a DEPTH-entry circular FIFO. It presents one pair per cycle on a/b toward the consumer stage, with its own valid/ready handshake. It also counts issued pairs and flags upstream handshake-protocol violations.

---
 rtl/operand_issue_fifo.sv | 92 +++++++++
 1 files changed

// File: rtl/operand_issue_fifo.sv
// Operand-pair issue FIFO: buffers {a,b} pairs from a producer and issues one per
// cycle to the operand stage, counting issued pairs and flagging upstream stalls that change.
module operand_issue_fifo #(
    parameter int unsigned N     = 10,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_a,
    input  logic [N-1:0]             in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             a,
    output logic [N-1:0]             b,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         issued_cnt,
    output logic                     proto_err
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned PAIR_W = 2 * N;

    logic [PAIR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PAIR_W-1:0] head;
    logic [PAIR_W-1:0] stall_pair;
    logic              stall_pending;
    logic              push;
    logic              pop;

    // Handshake flags derive only from registered occupancy.
    assign in_ready  = (count != OCC_W'(DEPTH));
    assign out_valid = (count != OCC_W'(0));
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head = out_valid ? mem[rd_ptr] : PAIR_W'(0);
    assign a    = head[PAIR_W-1:N];
    assign b    = head[N-1:0];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= PTR_W'(0);
            rd_ptr     <= PTR_W'(0);
            count      <= OCC_W'(0);
            issued_cnt <= CNT_W'(0);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                issued_cnt <= issued_cnt + CNT_W'(1);
            end
            if (push && !pop) begin
                count <= count + OCC_W'(1);
            end else if (pop && !push) begin
                count <= count - OCC_W'(1);
            end
        end
    end

    // A stalled offer must be held with unchanged data until it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_pending <= 1'b0;
            stall_pair    <= PAIR_W'(0);
            proto_err     <= 1'b0;
        end else begin
            if (stall_pending && (!in_valid || ({in_a, in_b} != stall_pair))) begin
                proto_err <= 1'b1;
            end
            stall_pending <= in_valid & ~in_ready;
            if (in_valid && !in_ready) begin
                stall_pair <= {in_a, in_b};
            end
        end
    end

endmodule
